// File: rtl/max_pool_2x2.sv
// max_pool_2x2: 2x2 stride-2 signed max-pooling over a raster-order single-channel feature map.
// Optional o_frame_done port is enabled by defining MAXPOOL_FRAME_DONE_EN.
`default_nettype none

module max_pool_2x2 #(
    parameter int BIT_WIDTH = 32,
    parameter int IMG_W     = 24,
    parameter int IMG_H     = 24
) (
    input  logic                 clk,
    input  logic                 global_rst_n,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [BIT_WIDTH-1:0] i_data,
    output logic [BIT_WIDTH-1:0] o_data,
`ifdef MAXPOOL_FRAME_DONE_EN
    output logic                 o_frame_done,
`endif
    output logic                 o_ce
);

    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int HALF = IMG_W / 2;
    localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [BIT_WIDTH-1:0] left_q, left_d;
    logic [BIT_WIDTH-1:0] data_q, data_d;
    logic                 oce_q, oce_d;
    logic                 done_q, done_d;

    // Horizontal maxima from the even row of the current window pair; never reset.
    logic [BIT_WIDTH-1:0] lbuf_q [HALF];
    logic                 lb_we;
    logic [LW-1:0]        lb_idx;
    logic [BIT_WIDTH-1:0] hmax;
    logic [BIT_WIDTH-1:0] lb_rd;

    assign lb_idx = LW'(col_q >> 1);
    assign lb_rd  = lbuf_q[lb_idx];
    assign hmax   = ($signed(left_q) > $signed(i_data)) ? left_q : i_data;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        left_d = left_q;
        data_d = '0;
        oce_d  = 1'b0;
        done_d = 1'b0;
        lb_we  = 1'b0;
        if (rst) begin
            col_d  = '0;
            row_d  = '0;
            left_d = '0;
        end else if (ce) begin
            if (!col_q[0]) begin
                left_d = i_data;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                data_d = ($signed(lb_rd) > $signed(hmax)) ? lb_rd : hmax;
                oce_d  = 1'b1;
                done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
            end

            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            left_q <= '0;
            data_q <= '0;
            oce_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            left_q <= left_d;
            data_q <= data_d;
            oce_q  <= oce_d;
            done_q <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we) begin
            lbuf_q[lb_idx] <= hmax;
        end
    end

    assign o_data = data_q;
    assign o_ce   = oce_q;

`ifdef MAXPOOL_FRAME_DONE_EN
    assign o_frame_done = done_q;
`else
    logic unused_done;
    assign unused_done = done_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_max_pool_2x2.sv
// tb_max_pool_2x2: table-driven directed check of max_pool_2x2 on a 4x4 map, plus async-reset sequences.
`default_nettype none

module tb_max_pool_2x2;

    localparam int BW = 32;

    logic                 clk = 1'b0;
    logic                 global_rst_n;
    logic                 rst;
    logic                 ce;
    logic [BW-1:0]        i_data;
    logic [BW-1:0]        o_data;
    logic                 o_ce;
`ifdef MAXPOOL_FRAME_DONE_EN
    logic                 o_frame_done;
`endif

    max_pool_2x2 #(.BIT_WIDTH(BW), .IMG_W(4), .IMG_H(4)) dut (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .rst          (rst),
        .ce           (ce),
        .i_data       (i_data),
        .o_data       (o_data),
`ifdef MAXPOOL_FRAME_DONE_EN
        .o_frame_done (o_frame_done),
`endif
        .o_ce         (o_ce)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          ce;
        logic          rst;
        logic [BW-1:0] d;
        logic          eoce;
        logic [BW-1:0] edata;
        logic          edone;
    } vec_t;

    vec_t tbl[$];
    int   pix[16];
    int   ex[4];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic done_actual();
`ifdef MAXPOOL_FRAME_DONE_EN
        return o_frame_done;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push(input logic c, input logic r, input int d,
                        input logic eo, input int ed, input logic edn);
        vec_t v;
        v.ce = c; v.rst = r; v.d = d; v.eoce = eo; v.edata = ed; v.edone = edn;
        tbl.push_back(v);
    endtask

    // One frame from pix[]; windows complete on pixels 5, 7, 13, 15 with results ex[0..3].
    task automatic add_frame(input bit gaps);
        for (int i = 0; i < 16; i++) begin
            case (i)
                5:       push(1, 0, pix[i], 1, ex[0], 0);
                7:       push(1, 0, pix[i], 1, ex[1], 0);
                13:      push(1, 0, pix[i], 1, ex[2], 0);
                15:      push(1, 0, pix[i], 1, ex[3], 1);
                default: push(1, 0, pix[i], 0, 0, 0);
            endcase
            if (gaps) push(0, 0, 32'h0BAD, 0, 0, 0);
        end
    endtask

    task automatic check(input string name, input logic eo, input logic [BW-1:0] ed, input logic edn);
        logic dn;
        dn = done_actual();
        n_vec++;
        if (o_ce !== eo || o_data !== ed
`ifdef MAXPOOL_FRAME_DONE_EN
            || dn !== edn
`endif
           ) begin
            n_err++;
            $display("FAIL %s: got o_ce=%0b o_data=%0d done=%0b, want o_ce=%0b o_data=%0d done=%0b",
                     name, o_ce, $signed(o_data), dn, eo, $signed(ed), edn);
        end
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            ce     = tbl[i].ce;
            rst    = tbl[i].rst;
            i_data = tbl[i].d;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", name, i), tbl[i].eoce, tbl[i].edata, tbl[i].edone);
        end
        tbl.delete();
    endtask

    task automatic ramp(input int base);
        for (int i = 0; i < 16; i++) pix[i] = base + i;
        ex[0] = base + 5; ex[1] = base + 7; ex[2] = base + 13; ex[3] = base + 15;
    endtask

    initial begin
        global_rst_n = 1'b1;
        rst    = 1'b0;
        ce     = 1'b0;
        i_data = '0;

        #3 global_rst_n = 1'b0;
        #1 check("reset_state", 0, 0, 0);
        repeat (2) @(negedge clk);
        global_rst_n = 1'b1;

        // Sync clear with ce low, then ascending ramp.
        push(0, 1, 0, 0, 0, 0);
        ramp(0);
        add_frame(0);
        run_table("ascending");

        for (int i = 0; i < 16; i++) pix[i] = 15 - i;
        ex[0] = 15; ex[1] = 13; ex[2] = 7; ex[3] = 5;
        add_frame(0);
        run_table("descending");

        for (int i = 0; i < 16; i++) pix[i] = -8;
        pix[9] = -3;
        ex[0] = -8; ex[1] = -8; ex[2] = -3; ex[3] = -8;
        add_frame(0);
        run_table("signed");

        ramp(0);
        add_frame(1);
        run_table("ce_gaps");

        // Partial frame, sync rst together with ce (pixel dropped), then a clean frame.
        ramp(0);
        for (int i = 0; i < 6; i++) push(1, 0, i, (i == 5), (i == 5) ? 5 : 0, 0);
        push(1, 1, 99, 0, 0, 0);
        add_frame(0);
        run_table("sync_rst_midframe");

        ramp(0);
        add_frame(0);
        ramp(100);
        add_frame(0);
        run_table("back_to_back");

        // Async reset mid-cycle while o_ce is high from the sixth pixel.
        for (int i = 0; i < 6; i++) push(1, 0, i, (i == 5), (i == 5) ? 5 : 0, 0);
        run_table("async_pre");
        #2;
        ce = 1'b0;
        global_rst_n = 1'b0;
        #1 check("async_midframe", 0, 0, 0);
        @(negedge clk);
        global_rst_n = 1'b1;
        @(posedge clk);
        #1 check("async_release_idle", 0, 0, 0);
        ramp(0);
        add_frame(0);
        run_table("after_async");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
